// File: rtl/varredura_matriz.sv
`timescale 1ns/1ps
// varredura_matriz: 5x7 LED matrix column scanner. The block holds a shadow
// buffer that changes only at frame boundaries, so no displayed frame mixes
// old and new data. It also overlays an optional blinking cursor on one dot.
module varredura_matriz #(
  parameter int DIV   = 50000,
  parameter int BLINK = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] coluna1,
  input  logic [6:0] coluna2,
  input  logic [6:0] coluna3,
  input  logic [6:0] coluna4,
  input  logic [6:0] coluna5,
  input  logic       atualizar,
  output logic       pronto,
  input  logic       cursor_en,
  input  logic [2:0] cursor_col,
  input  logic [2:0] cursor_lin,
  output logic [4:0] colunas,
  output logic [6:0] linhas
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam int FW = (BLINK > 1) ? $clog2(BLINK + 1) : 1;
  localparam logic [FW-1:0] FMAX = FW'(BLINK - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic          tick;
  logic          frame_end;
  logic          load;
  logic          pending;
  logic [FW-1:0] fcnt;
  logic          fase;
  logic          fase_nxt;
  logic [6:0]    shadow [5];
  logic [6:0]    dado_nxt;
  logic [6:0]    linhas_nxt;

  // Flips the cursor dot when the cursor is enabled, in its visible blink
  // phase, inside the matrix, and on the column about to be shown.
  function automatic logic [6:0] aplica_cursor(
    input logic [6:0] dado,
    input logic       en,
    input logic       fase_vis,
    input logic [2:0] col,
    input logic [2:0] lin,
    input logic [2:0] atual
  );
    logic [6:0] mascara;
    mascara = '0;
    if (en && fase_vis && (col <= 3'd4) && (lin <= 3'd6) && (col == atual))
      mascara = 7'(1) << lin;
    return dado ^ mascara;
  endfunction

  // Column index to one-hot enable. Any out-of-range index still yields a
  // valid one-hot value.
  function automatic logic [4:0] decodifica(input logic [2:0] i);
    logic [4:0] r;
    case (i)
      3'd1:    r = 5'b00010;
      3'd2:    r = 5'b00100;
      3'd3:    r = 5'b01000;
      3'd4:    r = 5'b10000;
      default: r = 5'b00001;
    endcase
    return r;
  endfunction

  // Scan timing decode: tick, frame boundary, load decision, next blink phase.
  always_comb begin
    tick      = (presc == PMAX);
    frame_end = tick && (idx == 3'd4);
    load      = frame_end && (pending || atualizar);
    idx_nxt   = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    fase_nxt  = (frame_end && (fcnt == FMAX)) ? ~fase : fase;
  end

  // Row data for the upcoming column. At a loading frame boundary the next
  // column is column 0, and it takes the new data directly, so the new frame
  // starts with the new buffer.
  always_comb begin
    dado_nxt = 7'b1111111;
    case (idx_nxt)
      3'd0:    dado_nxt = load ? coluna1 : shadow[0];
      3'd1:    dado_nxt = shadow[1];
      3'd2:    dado_nxt = shadow[2];
      3'd3:    dado_nxt = shadow[3];
      3'd4:    dado_nxt = shadow[4];
      default: dado_nxt = 7'b1111111;
    endcase
    linhas_nxt = aplica_cursor(dado_nxt, cursor_en, fase_nxt,
                               cursor_col, cursor_lin, idx_nxt);
  end

  // Prescaler: 0..DIV-1, wraps on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // Column index advances once per tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     idx <= 3'd0;
    else if (tick) idx <= idx_nxt;
  end

  // Update request handshake. A pending request absorbs repeated pulses,
  // and pronto follows the actual load by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      pronto <= load;
      if (load)           pending <= 1'b0;
      else if (atualizar) pending <= 1'b1;
    end
  end

  // Shadow buffer: captures the column inputs only at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) shadow[i] <= 7'b1111111;
    end else if (load) begin
      shadow[0] <= coluna1;
      shadow[1] <= coluna2;
      shadow[2] <= coluna3;
      shadow[3] <= coluna4;
      shadow[4] <= coluna5;
    end
  end

  // Frame counter and cursor blink phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
      fase <= 1'b0;
    end else if (frame_end) begin
      fcnt <= (fcnt == FMAX) ? '0 : fcnt + FW'(1);
      fase <= fase_nxt;
    end
  end

  // Registered matrix drive, refreshed on every tick for the new column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      colunas <= 5'b00001;
      linhas  <= 7'b1111111;
    end else if (tick) begin
      colunas <= decodifica(idx_nxt);
      linhas  <= linhas_nxt;
    end
  end

endmodule

// File: tb/tb_varredura_matriz.sv
`timescale 1ns/1ps
// Bench for varredura_matriz: a cycle-count based reference model, directed
// scenarios with literal expectations, and a randomized phase.
module tb_varredura_matriz;

  localparam int DIV   = 4;
  localparam int BLINK = 2;
  localparam int FR    = 5 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] coluna1, coluna2, coluna3, coluna4, coluna5;
  logic       atualizar;
  logic       pronto;
  logic       cursor_en;
  logic [2:0] cursor_col;
  logic [2:0] cursor_lin;
  logic [4:0] colunas;
  logic [6:0] linhas;

  int tests = 0;
  int fails = 0;
  int npronto = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  varredura_matriz #(.DIV(DIV), .BLINK(BLINK)) dut (
    .clk(clk), .reset(reset),
    .coluna1(coluna1), .coluna2(coluna2), .coluna3(coluna3),
    .coluna4(coluna4), .coluna5(coluna5),
    .atualizar(atualizar), .pronto(pronto),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_lin(cursor_lin),
    .colunas(colunas), .linhas(linhas)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from k, the number of clock edges
  // since reset was released.
  int         k;
  bit         mpend;
  bit         mpron;
  logic [6:0] mbuf [5];
  int         ecol;
  logic [6:0] elin;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0; mpend = 0; mpron = 0; ecol = 0; elin = 7'h7F;
      for (int i = 0; i < 5; i++) mbuf[i] = 7'h7F;
    end else begin
      int t;
      bit is_tick, fe;
      logic [6:0] d;
      k++;
      is_tick = (k % DIV) == 0;
      t = k / DIV;
      fe = is_tick && (t % 5 == 0);
      mpron = 0;
      if (fe && (mpend || atualizar)) begin
        mbuf[0] = coluna1; mbuf[1] = coluna2; mbuf[2] = coluna3;
        mbuf[3] = coluna4; mbuf[4] = coluna5;
        mpend = 0; mpron = 1;
      end else if (atualizar) begin
        mpend = 1;
      end
      if (is_tick) begin
        ecol = t % 5;
        d = mbuf[ecol];
        if (cursor_en && (((t / 5) / BLINK) % 2 == 1) && (int'(cursor_col) == ecol) && cursor_lin < 7)
          d[cursor_lin] = ~d[cursor_lin];
        elin = d;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (pronto === 1'b1) npronto++;
    if (chk_on) begin
      chk("model colunas", colunas, 32'(1) << ecol);
      chk("model linhas", linhas, elin);
      chk("model pronto", pronto, mpron);
    end
  end

  task automatic ciclos(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic espera_col(input logic [4:0] alvo, input string nm);
    int n = 0;
    while (colunas !== alvo && n < 100) begin @(negedge clk); n++; end
    chk({nm, " wait"}, colunas, alvo);
  endtask

  task automatic espera_pronto(input string nm);
    int n = 0;
    while (pronto !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    chk({nm, " pronto"}, pronto, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] seq [6];
    int n, p0, a, b, c;
    seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    reset = 1'b1;
    coluna1 = 7'h7F; coluna2 = 7'h7F; coluna3 = 7'h7F; coluna4 = 7'h7F; coluna5 = 7'h7F;
    atualizar = 0; cursor_en = 0; cursor_col = 0; cursor_lin = 0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset colunas", colunas, 5'b00001);
    chk("reset linhas", linhas, 7'h7F);
    chk("reset pronto", pronto, 0);
    @(posedge clk); #2 reset = 1'b0;

    // Scan after reset
    for (int i = 0; i < 6; i++) begin
      espera_col(seq[i], "scan");
      chk("scan linhas", linhas, 7'h7F);
    end
    n = 0;
    while (colunas === 5'b00001 && n < 50) begin n++; @(negedge clk); end
    chk("scan dwell", n, DIV);

    // Load mid-frame
    espera_col(5'b00100, "load start");
    @(posedge clk); #2;
    coluna1 = 7'b0111100; coluna5 = 7'b1110111; atualizar = 1;
    p0 = npronto;
    ciclos(1); atualizar = 0;
    espera_pronto("load");
    chk("load col0 sel", colunas, 5'b00001);
    chk("load col0 data", linhas, 7'b0111100);
    espera_col(5'b10000, "load col4");
    chk("load col4 data", linhas, 7'b1110111);
    ciclos(30);
    chk("load pronto count", npronto, p0 + 1);

    // Double request inside one frame
    espera_col(5'b00010, "dbl start");
    @(posedge clk); #2;
    coluna2 = 7'b1010101; atualizar = 1;
    p0 = npronto;
    ciclos(1); atualizar = 0;
    ciclos(2); coluna2 = 7'b0001111; atualizar = 1;
    ciclos(1); atualizar = 0;
    espera_pronto("dbl");
    espera_col(5'b00010, "dbl col1");
    chk("dbl col1 data", linhas, 7'b0001111);
    ciclos(25);
    chk("dbl pronto count", npronto, p0 + 1);

    // Request coincident with frame_end
    espera_col(5'b01000, "coinc pre");
    espera_col(5'b10000, "coinc col4");
    repeat (DIV - 1) @(posedge clk);
    #2;
    coluna1 = 7'b1100011; atualizar = 1;
    p0 = npronto;
    @(posedge clk); #1;
    chk("coinc pronto", pronto, 1);
    chk("coinc col0 sel", colunas, 5'b00001);
    chk("coinc col0 data", linhas, 7'b1100011);
    #1 atualizar = 0;
    ciclos(25);
    chk("coinc pronto count", npronto, p0 + 1);

    // Reset while a load is pending in column 3
    espera_col(5'b01000, "rst start");
    @(posedge clk); #2 atualizar = 1;
    @(posedge clk); #2 atualizar = 0;
    p0 = npronto;
    #1 reset = 1'b1;
    #1;
    chk("rst colunas", colunas, 5'b00001);
    chk("rst linhas", linhas, 7'h7F);
    chk("rst pronto", pronto, 0);
    cursor_en = 1; cursor_col = 3'd2; cursor_lin = 3'd0;
    ciclos(3);
    reset = 1'b0;

    // Blank buffer plus blinking cursor on column 2, row 0
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      if (colunas === 5'b00100) begin
        if (linhas === 7'b1111111) a++;
        else if (linhas === 7'b1111110) b++;
      end else if (linhas !== 7'h7F) c++;
    end
    chk("cursor off cycles", a, 2 * DIV);
    chk("cursor on cycles", b, 2 * DIV);
    chk("blank buffer", c, 0);
    chk("rst no pronto", npronto, p0);
    cursor_col = 3'd5;
    c = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      if (linhas !== 7'h7F) c++;
    end
    chk("cursor col5 none", c, 0);

    // Randomized operation
    @(posedge clk); #2;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 3) == 0) coluna1 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) coluna2 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) coluna3 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) coluna4 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) coluna5 = 7'($urandom);
      atualizar = ($urandom_range(0, 24) == 0);
      if (i % 7 == 0) begin
        cursor_en  = ($urandom_range(0, 3) != 0);
        cursor_col = 3'($urandom_range(0, 7));
        cursor_lin = 3'($urandom_range(0, 7));
      end
      if (i == 450) reset = 1'b1;
      if (i == 453) reset = 1'b0;
      ciclos(1);
    end
    atualizar = 0;
    ciclos(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
